scan_chain_ctrl: RTL and testbench

- On-chip host-side controller for the qtcore scan/debug chain. It replaces bench-only bit-banging with hardware: it streams a parametrised-length scan chain in and out through byte-wide valid/ready ports, pulses processor reset, and runs the processor for a bounded cycle budget until it halts.
- It sits between a host-facing byte/command interface and the processor's scan_enable, scan_in, scan_out, proc_en and reset pins. All are on the same clock.

---
 rtl/scan_chain_ctrl_if.sv | 47 ++++
 rtl/scan_chain_ctrl.sv | 143 ++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_chain_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : scan_chain_ctrl_if
// Brief  : Host command, scan byte stream and processor pins for scan_chain_ctrl.
// Rev    : 1.0
//------------------------------------------------------------------------------
interface scan_chain_ctrl_if #(
    parameter int RUN_W = 16
);
    logic             cmd_valid_in;
    logic             cmd_ready_out;
    logic [1:0]       cmd_op_in;
    logic [RUN_W-1:0] cmd_arg_in;
    logic             wr_valid_in;
    logic             wr_ready_out;
    logic [7:0]       wr_data_in;
    logic             rd_valid_out;
    logic             rd_ready_in;
    logic [7:0]       rd_data_out;
    logic             abort_in;
    logic             busy_out;
    logic             done_out;
    logic             halted_out;
    logic [RUN_W-1:0] cycles_run_out;
    logic             proc_rst_out;
    logic             proc_en_out;
    logic             scan_enable_out;
    logic             scan_data_out;
    logic             scan_data_in;

    modport master (
        output cmd_valid_in, cmd_op_in, cmd_arg_in, wr_valid_in, wr_data_in,
               rd_ready_in, abort_in, scan_data_in,
        input  cmd_ready_out, wr_ready_out, rd_valid_out, rd_data_out, busy_out,
               done_out, halted_out, cycles_run_out, proc_rst_out, proc_en_out,
               scan_enable_out, scan_data_out
    );

    modport slave (
        input  cmd_valid_in, cmd_op_in, cmd_arg_in, wr_valid_in, wr_data_in,
               rd_ready_in, abort_in, scan_data_in,
        output cmd_ready_out, wr_ready_out, rd_valid_out, rd_data_out, busy_out,
               done_out, halted_out, cycles_run_out, proc_rst_out, proc_en_out,
               scan_enable_out, scan_data_out
    );
endinterface
`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : scan_chain_ctrl
// Brief  : Streams the qtcore scan chain byte-wise, pulses reset, runs to halt.
// Rev    : 1.0
//------------------------------------------------------------------------------
module scan_chain_ctrl #(
    parameter int CHAIN_LEN  = 176,
    parameter int RUN_W      = 16,
    parameter int MIN_RUN    = 4,
    parameter int RST_CYCLES = 2
) (
    input  wire logic        clk_in,
    input  wire logic        rst_in,
    scan_chain_ctrl_if.slave bus
);
    localparam int               C_NBYTES   = CHAIN_LEN / 8;
    localparam int               C_BYTES_W  = $clog2(C_NBYTES + 1);
    localparam logic [RUN_W-1:0] C_MIN_RUN  = RUN_W'(MIN_RUN);
    localparam logic [RUN_W-1:0] C_RST_LAST = RUN_W'(RST_CYCLES - 1);

    generate
        if (CHAIN_LEN % 8 != 0) begin : g_bad_chain_len
            $error("scan_chain_ctrl: CHAIN_LEN must be a multiple of 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST     = 3'd1,
        S_X_WAIT  = 3'd2,
        S_X_SHIFT = 3'd3,
        S_X_OUT   = 3'd4,
        S_RUN     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t               r_state;
    logic [RUN_W-1:0]     r_arg;
    logic [RUN_W-1:0]     r_cnt;
    logic [RUN_W-1:0]     r_cycles;
    logic                 r_halted;
    logic [C_BYTES_W-1:0] r_bytes;
    logic [2:0]           r_bit;
    logic [7:0]           r_tx_sr;
    logic [7:0]           r_rx_sr;

    logic w_abort;
    logic w_go;

    assign w_abort = bus.abort_in && (r_state != S_IDLE) && (r_state != S_DONE);
    // scan_data_in is only a trustworthy halt flag once MIN_RUN cycles have run
    assign w_go    = (r_cnt < r_arg) && ((r_cnt < C_MIN_RUN) || !bus.scan_data_in);

    assign bus.cmd_ready_out   = (r_state == S_IDLE);
    assign bus.busy_out        = (r_state != S_IDLE);
    assign bus.wr_ready_out    = (r_state == S_X_WAIT) && !w_abort;
    assign bus.rd_valid_out    = (r_state == S_X_OUT) && !w_abort;
    assign bus.rd_data_out     = r_rx_sr;
    assign bus.done_out        = (r_state == S_DONE);
    assign bus.halted_out      = r_halted;
    assign bus.cycles_run_out  = r_cycles;
    assign bus.proc_rst_out    = (r_state == S_RST) && !w_abort;
    assign bus.proc_en_out     = (r_state == S_RUN) && w_go && !w_abort;
    assign bus.scan_enable_out = (r_state == S_X_SHIFT) && !w_abort;
    assign bus.scan_data_out   = (r_state == S_X_SHIFT) && r_tx_sr[7];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state  <= S_IDLE;
            r_arg    <= '0;
            r_cnt    <= '0;
            r_cycles <= '0;
            r_halted <= 1'b0;
            r_bytes  <= '0;
            r_bit    <= '0;
            r_tx_sr  <= '0;
            r_rx_sr  <= '0;
        end else if (w_abort) begin
            r_state <= S_DONE;
            if (r_state == S_RUN) begin
                r_cycles <= r_cnt;
                r_halted <= 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid_in) begin
                        r_cnt <= '0;
                        case (bus.cmd_op_in)
                            2'b00: r_state <= S_DONE;
                            2'b01: r_state <= S_RST;
                            2'b10: begin
                                r_bytes <= C_BYTES_W'(C_NBYTES);
                                r_state <= S_X_WAIT;
                            end
                            default: begin
                                r_arg    <= bus.cmd_arg_in;
                                r_halted <= 1'b0;
                                r_state  <= S_RUN;
                            end
                        endcase
                    end
                end
                S_RST: begin
                    r_cnt <= r_cnt + RUN_W'(1);
                    if (r_cnt == C_RST_LAST) r_state <= S_DONE;
                end
                S_X_WAIT: begin
                    if (bus.wr_valid_in) begin
                        r_tx_sr <= bus.wr_data_in;
                        r_bit   <= '0;
                        r_state <= S_X_SHIFT;
                    end
                end
                S_X_SHIFT: begin
                    r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                    r_rx_sr <= {r_rx_sr[6:0], bus.scan_data_in};
                    r_bit   <= r_bit + 3'd1;
                    if (r_bit == 3'd7) r_state <= S_X_OUT;
                end
                S_X_OUT: begin
                    if (bus.rd_ready_in) begin
                        r_bytes <= r_bytes - C_BYTES_W'(1);
                        r_state <= (r_bytes == C_BYTES_W'(1)) ? S_DONE : S_X_WAIT;
                    end
                end
                S_RUN: begin
                    if (w_go) begin
                        r_cnt <= r_cnt + RUN_W'(1);
                    end else begin
                        r_halted <= (r_cnt >= C_MIN_RUN) && bus.scan_data_in;
                        r_cycles <= r_cnt;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_scan_chain_ctrl
// Brief  : Directed bench with a shift-register processor model and a scoreboard.
// Rev    : 1.0
//------------------------------------------------------------------------------
module tb_scan_chain_ctrl;
    localparam int CHAIN_LEN  = 176;
    localparam int RUN_W      = 16;
    localparam int MIN_RUN    = 4;
    localparam int RST_CYCLES = 2;
    localparam int NBYTES     = CHAIN_LEN / 8;
    localparam int NEVER      = 1000000;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    scan_chain_ctrl_if #(.RUN_W(RUN_W)) bus();

    scan_chain_ctrl #(
        .CHAIN_LEN (CHAIN_LEN),
        .RUN_W     (RUN_W),
        .MIN_RUN   (MIN_RUN),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    int n_pass   = 0;
    int n_checks = 0;
    bit chk_en   = 1'b0;

    // processor model: scan chain, enabled-cycle count, halt after halt_at enabled cycles
    logic [CHAIN_LEN-1:0] chain;
    logic [CHAIN_LEN-1:0] preload_val;
    bit                   preload_req = 1'b0;
    int en_total   = 0;
    int sc_total   = 0;
    int done_total = 0;
    int rst_total  = 0;
    bit run_mode   = 1'b0;
    int run_base   = 0;
    int halt_at    = NEVER;

    logic [7:0] exp_rd[$];
    logic [7:0] exp_b;

    assign bus.scan_data_in = run_mode ? ((en_total - run_base) >= halt_at)
                                       : chain[CHAIN_LEN-1];

    always @(posedge clk_in) begin
        if (preload_req) chain <= preload_val;
        else if (bus.scan_enable_out) chain <= {chain[CHAIN_LEN-2:0], bus.scan_data_out};
        if (bus.scan_enable_out) sc_total   <= sc_total + 1;
        if (bus.proc_en_out)     en_total   <= en_total + 1;
        if (bus.done_out)        done_total <= done_total + 1;
        if (bus.proc_rst_out)    rst_total  <= rst_total + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // every-cycle compare: structural rules plus scoreboard of captured bytes
    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("en_scan_exclusive", 32'(bus.proc_en_out & bus.scan_enable_out), 0);
            chk("ready_is_not_busy", 32'(bus.cmd_ready_out), 32'(!bus.busy_out));
            if (bus.rd_valid_out && bus.rd_ready_in) begin
                if (exp_rd.size() > 0) begin
                    exp_b = exp_rd.pop_front();
                    chk("rd_byte", 32'(bus.rd_data_out), 32'(exp_b));
                end else begin
                    chk("rd_extra_byte", 32'(bus.rd_valid_out && bus.rd_ready_in), 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [RUN_W-1:0] arg);
        int k = 0;
        bus.cmd_op_in    = op;
        bus.cmd_arg_in   = arg;
        bus.cmd_valid_in = 1'b1;
        while (!bus.cmd_ready_out && k < 50) begin tick(); k++; end
        chk("cmd_ready_timeout", 32'(bus.cmd_ready_out), 1);
        tick();
        bus.cmd_valid_in = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int lat);
        lat = 0;
        while (!bus.done_out && lat < bound) begin tick(); lat++; end
        chk("done_timeout", 32'(bus.done_out), 1);
    endtask

    task automatic run_test(input int arg, input int h);
        int lat, stop, d0, halt_exp;
        run_mode = 1'b1;
        halt_at  = h;
        run_base = en_total;
        d0       = done_total;
        stop     = (arg < ((h > MIN_RUN) ? h : MIN_RUN)) ? arg : ((h > MIN_RUN) ? h : MIN_RUN);
        halt_exp = (stop >= MIN_RUN) && (stop >= h);
        send_cmd(2'b11, RUN_W'(arg));
        wait_done(arg + 20, lat);
        chk("run_done_latency", 32'(lat), 32'(stop + 1));
        tick();
        chk("run_cycles_run", 32'(bus.cycles_run_out), 32'(stop));
        chk("run_halted", 32'(bus.halted_out), 32'(halt_exp));
        chk("run_en_cycles", 32'(en_total - run_base), 32'(stop));
        chk("run_one_done", 32'(done_total - d0), 1);
        chk("run_idle_after", 32'(bus.busy_out), 0);
    endtask

    task automatic exchange(input int stall_rd_at, input int stall_wr_at);
        int k;
        int sc0 = sc_total;
        run_mode = 1'b0;
        for (int i = 0; i < NBYTES; i++) exp_rd.push_back(8'(i));
        send_cmd(2'b10, '0);
        for (int i = 0; i < NBYTES; i++) begin
            if (i == stall_wr_at) begin
                for (int s = 0; s < 5; s++) begin
                    chk("wr_stall_scan_en", 32'(bus.scan_enable_out), 0);
                    chk("wr_stall_ready", 32'(bus.wr_ready_out), 1);
                    tick();
                end
            end
            bus.wr_data_in  = 8'hA0 + 8'(i);
            bus.wr_valid_in = 1'b1;
            k = 0;
            while (!bus.wr_ready_out && k < 50) begin tick(); k++; end
            chk("wr_ready_timeout", 32'(bus.wr_ready_out), 1);
            tick();
            bus.wr_valid_in = 1'b0;
            k = 0;
            while (!bus.rd_valid_out && k < 50) begin tick(); k++; end
            chk("rd_valid_timeout", 32'(bus.rd_valid_out), 1);
            if (i == stall_rd_at) begin
                for (int s = 0; s < 10; s++) begin
                    chk("rd_stall_scan_en", 32'(bus.scan_enable_out), 0);
                    chk("rd_stall_valid", 32'(bus.rd_valid_out), 1);
                    tick();
                end
            end
            bus.rd_ready_in = 1'b1;
            tick();
            bus.rd_ready_in = 1'b0;
        end
        chk("x_done_pulse", 32'(bus.done_out), 1);
        tick();
        chk("x_back_idle", 32'(bus.cmd_ready_out), 1);
        chk("x_scan_en_cycles", 32'(sc_total - sc0), 32'(CHAIN_LEN));
        chk("x_all_bytes_read", 32'(exp_rd.size()), 0);
        for (int i = 0; i < NBYTES; i++)
            chk("x_chain_byte", 32'(chain[CHAIN_LEN-1-8*i -: 8]), 32'(8'hA0 + 8'(i)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, r0;
        rst_in           = 1'b0;
        bus.cmd_valid_in = 1'b0;
        bus.cmd_op_in    = 2'b00;
        bus.cmd_arg_in   = '0;
        bus.wr_valid_in  = 1'b0;
        bus.wr_data_in   = 8'h00;
        bus.rd_ready_in  = 1'b0;
        bus.abort_in     = 1'b0;
        for (int i = 0; i < NBYTES; i++) preload_val[CHAIN_LEN-1-8*i -: 8] = 8'(i);
        preload_req = 1'b1;
        tick(); tick(); tick();
        preload_req = 1'b0;
        chk_en = 1'b1;

        chk("rst_cmd_ready", 32'(bus.cmd_ready_out), 1);
        chk("rst_busy", 32'(bus.busy_out), 0);
        chk("rst_done", 32'(bus.done_out), 0);
        chk("rst_halted", 32'(bus.halted_out), 0);
        chk("rst_cycles", 32'(bus.cycles_run_out), 0);
        chk("rst_pins", 32'({bus.proc_rst_out, bus.proc_en_out, bus.scan_enable_out,
                             bus.scan_data_out, bus.wr_ready_out, bus.rd_valid_out}), 0);
        chk("rst_rd_data", 32'(bus.rd_data_out), 0);
        rst_in = 1'b1;
        tick();

        send_cmd(2'b00, '0);
        chk("nop_done", 32'(bus.done_out), 1);
        tick();

        // RESET op with a blocked command arriving mid-pulse
        r0 = rst_total;
        e0 = en_total;
        send_cmd(2'b01, '0);
        chk("rstop_pulse_c1", 32'(bus.proc_rst_out), 1);
        chk("rstop_not_ready", 32'(bus.cmd_ready_out), 0);
        bus.cmd_op_in    = 2'b11;
        bus.cmd_arg_in   = RUN_W'(5);
        bus.cmd_valid_in = 1'b1;
        tick();
        chk("rstop_pulse_c2", 32'(bus.proc_rst_out), 1);
        bus.cmd_valid_in = 1'b0;
        tick();
        chk("rstop_done", 32'(bus.done_out), 1);
        chk("rstop_pulse_off", 32'(bus.proc_rst_out), 0);
        tick();
        chk("rstop_pulse_len", 32'(rst_total - r0), 32'(RST_CYCLES));
        chk("rstop_blocked_cmd", 32'(en_total - e0), 0);
        chk("rstop_idle", 32'(bus.cmd_ready_out), 1);

        exchange(NEVER, NEVER);
        for (int i = 0; i < NBYTES; i++) preload_val[CHAIN_LEN-1-8*i -: 8] = 8'(i);
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
        exchange(3, 7);

        run_test(8, 2);
        chk("halt_cycles_literal", 32'(bus.cycles_run_out), 4);
        chk("halt_flag_literal", 32'(bus.halted_out), 1);
        run_test(0, NEVER);
        chk("zero_cycles_literal", 32'(bus.cycles_run_out), 0);
        run_test(8, NEVER);
        chk("budget_cycles_literal", 32'(bus.cycles_run_out), 8);
        chk("budget_halt_literal", 32'(bus.halted_out), 0);

        // abort on the 3rd shift cycle
        run_mode = 1'b0;
        send_cmd(2'b10, '0);
        bus.wr_data_in  = 8'h5A;
        bus.wr_valid_in = 1'b1;
        tick();
        bus.wr_valid_in = 1'b0;
        tick();
        tick();
        chk("abort_pre_scan_en", 32'(bus.scan_enable_out), 1);
        bus.abort_in = 1'b1;
        #1;
        chk("abort_scan_en_drop", 32'(bus.scan_enable_out), 0);
        tick();
        bus.abort_in = 1'b0;
        chk("abort_done", 32'(bus.done_out), 1);
        tick();
        chk("abort_idle", 32'(bus.cmd_ready_out), 1);
        chk("abort_not_busy", 32'(bus.busy_out), 0);

        // reset in the middle of a run
        run_mode = 1'b1;
        halt_at  = NEVER;
        run_base = en_total;
        send_cmd(2'b11, RUN_W'(100));
        tick();
        tick();
        chk("midrun_en", 32'(bus.proc_en_out), 1);
        chk("midrun_cycles_held", 32'(bus.cycles_run_out), 8);
        rst_in = 1'b0;
        tick();
        chk("rstrun_en", 32'(bus.proc_en_out), 0);
        chk("rstrun_ready", 32'(bus.cmd_ready_out), 1);
        chk("rstrun_busy", 32'(bus.busy_out), 0);
        chk("rstrun_cycles", 32'(bus.cycles_run_out), 0);
        chk("rstrun_outs", 32'({bus.done_out, bus.halted_out, bus.proc_rst_out,
                                bus.scan_enable_out, bus.rd_valid_out, bus.wr_ready_out}), 0);
        rst_in = 1'b1;
        tick();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
